otter_mem_arbiter: RTL
======================

# otter_mem_arbiter

Single-outstanding memory port arbiter for the OTTER core. It shares one memory bus between three requesters: instruction fetch (IF), load/store data (DATA) and a debug/program loader (DBG). It sits between the pipeline's fetch and memory stages and the memory, and uses fixed priority with an IF anti-starvation override. A timeout retires a transaction that the memory never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte-enable width = DATA_W/8)
- MAX_SKIP, 4, consecutive lost arbitrations before IF is promoted; range 1..15
- TIMEOUT, 255, cycles in BUSY without MEM_ACK before forced error completion; range 1..255

Ports (X ∈ {IF, DATA, DBG}; each requester has the full set):
- CLK  in  1  clock; all state is updated on its rising edge
- RST_N  in  1  asynchronous active-low reset
- X_REQ  in  1  request valid; must be held stable until X_GNT
- X_WE  in  1  1 = write, 0 = read (IF_WE is ignored and treated as 0)
- X_ADDR  in  ADDR_W  byte address
- X_WDATA  in  DATA_W  write data
- X_BE  in  DATA_W/8  byte enables
- X_GNT  out  1  one-cycle pulse; the request was accepted this cycle
- X_RVALID  out  1  one-cycle pulse; response for X
- RDATA  out  DATA_W  shared read data, qualified by X_RVALID
- RERR  out  1  shared error flag, qualified by X_RVALID
- MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE  out  1/1/ADDR_W/DATA_W/DATA_W/8  registered memory command
- MEM_ACK  in  1  memory completion
- MEM_RDATA  in  DATA_W  memory read data, valid with MEM_ACK
- MEM_ERR  in  1  memory error, valid with MEM_ACK
- BUSY  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: arbitrate among asserted REQs. On a winner: pulse its GNT, latch its command, go to BUSY. With no REQ, stay in IDLE.
  - BUSY: hold MEM_REQ=1 and the latched command. On MEM_ACK, latch MEM_RDATA/MEM_ERR and go to RESP. If the timeout counter reaches TIMEOUT first, set RERR=1, RDATA=0 and go to RESP.
  - RESP: pulse RVALID to the latched owner. Arbitration runs in this cycle exactly as in IDLE, so back-to-back grants are possible. Next state is BUSY if a grant was made, otherwise IDLE.
- Priority: DBG > DATA > IF.
- Override: when skip_cnt == MAX_SKIP and IF_REQ=1, IF beats DATA. DBG still wins.
- skip_cnt (4 bit) tracks IF starvation:
  - increments on every grant to DATA or DBG while IF_REQ=1;
  - saturates at MAX_SKIP;
  - clears on an IF grant or whenever IF_REQ=0.
- Only one transaction is outstanding at a time. GNT is never asserted in BUSY.
- MEM_ACK outside BUSY is ignored: no RVALID, no state change.
- Timeout counter (8 bit) clears on entry to BUSY and increments each BUSY cycle without MEM_ACK. If MEM_ACK and the timeout occur in the same cycle, MEM_ACK wins.
- Stall contract: the pipeline stalls fetch while IF_REQ & ~IF_GNT, and stalls MEM while DATA_REQ & ~DATA_RVALID.

## Timing
- Reset values: state IDLE; all GNT/RVALID, MEM_REQ, MEM_WE, BUSY, RERR = 0; MEM_ADDR/WDATA/BE, RDATA = 0; skip_cnt = 0; timeout counter = 0.
- Reset is asynchronous. Asserting RST_N mid-transaction drops the transaction: no RVALID is produced and MEM_REQ falls immediately.
- GNT is combinational from REQ in IDLE/RESP (cycle T). MEM_REQ and the command registers are valid from T+1.
- Response latency:
  - MEM_ACK in cycle T+1+k gives RVALID in cycle T+2+k.
  - Minimum grant-to-RVALID is 2 cycles.
  - Peak throughput is one transaction per 2 cycles.
- Timeout: with no MEM_ACK, RVALID with RERR=1 arrives in cycle T+1+TIMEOUT.
- A requester may deassert REQ only after GNT. A REQ that drops before GNT is treated as withdrawn, not as an error.

## Structure
- Shared package otter_pkg holds:
  - typedef enum logic [1:0] {REQ_IF, REQ_DATA, REQ_DBG} mem_req_id_t
  - typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t
  - a packed struct mem_cmd_t {we, addr, wdata, be}
- One sub-module, otter_arb_pick: combinational priority picker. Inputs are the three REQs and the promote_if flag; outputs are grant_valid and grant_id.
- Everything else (FSM, counters, command/response registers) lives in otter_mem_arbiter.

## Test plan
- Single IF read to 0x0000_0100, memory acks after 3 cycles with 0xDEAD_BEEF → IF_GNT at T, IF_RVALID at T+5, RDATA=0xDEAD_BEEF, RERR=0.
- IF and DATA request together (DATA write 0x0000_2000, BE=4'b0011) → DATA granted first. IF is granted in DATA's RESP cycle. MEM_WE=1 only during DATA's BUSY.
- DATA held high continuously with IF_REQ=1, MAX_SKIP=4 → exactly 4 DATA grants, then an IF grant, then skip_cnt=0.
- DBG, DATA and IF all requesting with skip_cnt saturated → DBG is granted first, then IF (override), then DATA.
- No MEM_ACK, TIMEOUT=8 → RVALID with RERR=1 and RDATA=0 at T+9, FSM returns to IDLE. A MEM_ACK injected in IDLE afterwards → no RVALID.
- RST_N pulsed low in the second BUSY cycle → MEM_REQ=0 immediately, no RVALID. A request after reset release is granted normally.

Source files
------------

// File: rtl/otter_pkg.sv
// otter_pkg: shared types for the OTTER memory arbiter slice.
// Holds requester ids, arbiter FSM states and the latched memory command.
package otter_pkg;

    localparam int OTTER_ADDR_W = 32;
    localparam int OTTER_DATA_W = 32;
    localparam int OTTER_BE_W   = OTTER_DATA_W / 8;

    typedef enum logic [1:0] {
        REQ_IF,
        REQ_DATA,
        REQ_DBG
    } mem_req_id_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

    typedef struct packed {
        logic                    we;
        logic [OTTER_ADDR_W-1:0] addr;
        logic [OTTER_DATA_W-1:0] wdata;
        logic [OTTER_BE_W-1:0]   be;
    } mem_cmd_t;

    // Saturating 4-bit increment used by the IF starvation counter.
    function automatic logic [3:0] sat_inc4(
        input logic [3:0] v,
        input logic [3:0] lim
    );
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/otter_arb_pick.sv
// otter_arb_pick: combinational fixed-priority picker, DBG > DATA > IF.
// Ports: if_req/data_req/dbg_req, promote_if in; grant_valid, grant_id out.
module otter_arb_pick
    import otter_pkg::*;
(
    input  logic        if_req,
    input  logic        data_req,
    input  logic        dbg_req,
    input  logic        promote_if,
    output logic        grant_valid,
    output mem_req_id_t grant_id
);

    // promote_if is only ever set while if_req is high, so the final
    // branch always names a live requester when grant_valid is set.
    always_comb begin
        grant_valid = if_req | data_req | dbg_req;
        grant_id    = REQ_IF;
        if (dbg_req) begin
            grant_id = REQ_DBG;
        end else if (data_req && !promote_if) begin
            grant_id = REQ_DATA;
        end else begin
            grant_id = REQ_IF;
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: single-outstanding memory arbiter for IF, DATA and DBG.
// Ports: X_REQ/WE/ADDR/WDATA/BE in, X_GNT/X_RVALID, RDATA/RERR out,
//        MEM_* registered command out, MEM_ACK/RDATA/ERR in, BUSY out.
module otter_mem_arbiter
    import otter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_SKIP = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                CLK,
    input  logic                RST_N,

    input  logic                IF_REQ,
    input  logic                IF_WE,
    input  logic [ADDR_W-1:0]   IF_ADDR,
    input  logic [DATA_W-1:0]   IF_WDATA,
    input  logic [DATA_W/8-1:0] IF_BE,
    output logic                IF_GNT,
    output logic                IF_RVALID,

    input  logic                DATA_REQ,
    input  logic                DATA_WE,
    input  logic [ADDR_W-1:0]   DATA_ADDR,
    input  logic [DATA_W-1:0]   DATA_WDATA,
    input  logic [DATA_W/8-1:0] DATA_BE,
    output logic                DATA_GNT,
    output logic                DATA_RVALID,

    input  logic                DBG_REQ,
    input  logic                DBG_WE,
    input  logic [ADDR_W-1:0]   DBG_ADDR,
    input  logic [DATA_W-1:0]   DBG_WDATA,
    input  logic [DATA_W/8-1:0] DBG_BE,
    output logic                DBG_GNT,
    output logic                DBG_RVALID,

    output logic [DATA_W-1:0]   RDATA,
    output logic                RERR,

    output logic                MEM_REQ,
    output logic                MEM_WE,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic [DATA_W-1:0]   MEM_WDATA,
    output logic [DATA_W/8-1:0] MEM_BE,
    input  logic                MEM_ACK,
    input  logic [DATA_W-1:0]   MEM_RDATA,
    input  logic                MEM_ERR,

    output logic                BUSY
);

    localparam logic [3:0] SKIP_MAX = 4'(MAX_SKIP);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    mem_req_id_t       owner_q;
    mem_req_id_t       grant_id;
    mem_cmd_t          cmd_q;
    mem_cmd_t          cmd_sel;
    logic              mem_req_q;
    logic [3:0]        skip_q;
    logic [7:0]        to_cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rerr_q;

    logic              arb_open;
    logic              grant_valid;
    logic              grant;
    logic              promote_if;
    logic              to_hit;
    logic              in_busy;
    logic              in_resp;
    logic              if_we_unused;

    // Fetch is read-only; its WE input carries no meaning here.
    assign if_we_unused = IF_WE;

    assign in_busy    = (state_q == ARB_BUSY);
    assign in_resp    = (state_q == ARB_RESP);
    assign arb_open   = (state_q == ARB_IDLE) || in_resp;
    assign promote_if = IF_REQ && (skip_q == SKIP_MAX);
    assign grant      = arb_open && grant_valid;

    // The counter holds the number of BUSY cycles already spent, so the
    // last allowed cycle is TIMEOUT-1; an ACK in that cycle still wins.
    assign to_hit = in_busy && !MEM_ACK && (to_cnt_q == TO_LAST);

    otter_arb_pick u_pick (
        .if_req      (IF_REQ),
        .data_req    (DATA_REQ),
        .dbg_req     (DBG_REQ),
        .promote_if  (promote_if),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        cmd_sel = '0;
        unique case (grant_id)
            REQ_DBG: begin
                cmd_sel.we    = DBG_WE;
                cmd_sel.addr  = DBG_ADDR;
                cmd_sel.wdata = DBG_WDATA;
                cmd_sel.be    = DBG_BE;
            end
            REQ_DATA: begin
                cmd_sel.we    = DATA_WE;
                cmd_sel.addr  = DATA_ADDR;
                cmd_sel.wdata = DATA_WDATA;
                cmd_sel.be    = DATA_BE;
            end
            default: begin
                cmd_sel.we    = 1'b0;
                cmd_sel.addr  = IF_ADDR;
                cmd_sel.wdata = IF_WDATA;
                cmd_sel.be    = IF_BE;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (MEM_ACK || to_hit) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = grant ? ARB_BUSY : ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_req_q <= 1'b0;
            cmd_q     <= '0;
            owner_q   <= REQ_IF;
        end else begin
            mem_req_q <= (state_d == ARB_BUSY);
            if (grant) begin
                cmd_q   <= cmd_sel;
                owner_q <= grant_id;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_cnt_q <= '0;
        end else if (grant) begin
            to_cnt_q <= '0;
        end else if (in_busy && !MEM_ACK) begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else if (in_busy) begin
            if (MEM_ACK) begin
                rdata_q <= MEM_RDATA;
                rerr_q  <= MEM_ERR;
            end else if (to_hit) begin
                rdata_q <= '0;
                rerr_q  <= 1'b1;
            end
        end
    end

    // skip_q counts grants IF lost while it was asking; any gap in
    // IF_REQ forgives the history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            skip_q <= '0;
        end else if (!IF_REQ) begin
            skip_q <= '0;
        end else if (grant) begin
            if (grant_id == REQ_IF) begin
                skip_q <= '0;
            end else begin
                skip_q <= sat_inc4(skip_q, SKIP_MAX);
            end
        end
    end

    assign IF_GNT      = grant && (grant_id == REQ_IF);
    assign DATA_GNT    = grant && (grant_id == REQ_DATA);
    assign DBG_GNT     = grant && (grant_id == REQ_DBG);

    assign IF_RVALID   = in_resp && (owner_q == REQ_IF);
    assign DATA_RVALID = in_resp && (owner_q == REQ_DATA);
    assign DBG_RVALID  = in_resp && (owner_q == REQ_DBG);

    assign RDATA       = rdata_q;
    assign RERR        = rerr_q;

    assign MEM_REQ     = mem_req_q;
    assign MEM_WE      = mem_req_q && cmd_q.we;
    assign MEM_ADDR    = cmd_q.addr;
    assign MEM_WDATA   = cmd_q.wdata;
    assign MEM_BE      = cmd_q.be;

    assign BUSY        = (state_q != ARB_IDLE);

endmodule
